coef_table_loader: RTL and testbench
====================================

COEF_TABLE_LOADER -- requirements
Module: coef_table_loader

Interface
REQ-001 SHALL have parameter bus_C0, default 29, C0 coefficient width.
REQ-002 SHALL have parameter bus_C1, default 20, C1 coefficient width.
REQ-003 SHALL have parameter bus_C2, default 14, C2 coefficient width.
REQ-004 SHALL have parameter fn_bits, default 4, function-select width.
REQ-005 SHALL have parameter add_bits, default 7, table address width.
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  begin load, sampled in IDLE only.
REQ-009 SHALL have port fn_sel  input  fn_bits  target function table, sampled with start.
REQ-010 SHALL have port num_entries  input  add_bits+1  entry count, sampled with start.
REQ-011 SHALL have port abort  input  1  cancel load in progress.
REQ-012 SHALL have port s_valid  input  1  stream word valid.
REQ-013 SHALL have port s_data  input  32  stream word.
REQ-014 SHALL have port s_ready  output  1  stream word accepted when s_valid&&s_ready.
REQ-015 SHALL have port wr_en  output  1  table write strobe.
REQ-016 SHALL have port wr_fn  output  fn_bits  table select for write.
REQ-017 SHALL have port wr_addr  output  add_bits  entry address for write.
REQ-018 SHALL have ports wr_C0, wr_C1, wr_C2  output  bus_C0/bus_C1/bus_C2  coefficient write data.
REQ-019 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-020 States SHALL be IDLE, LD_C0, LD_C1, LD_C2, WRITE, LD_SUM (CHECKSUM_EN only), FIN.
REQ-021 IDLE + start: fn_sel>9 or num_entries>2^add_bits -> FIN with err=1, no writes; num_entries==0 -> FIN, err=0, no writes; else -> LD_C0, wr_addr=0.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 s_ready SHALL be 1 exactly in LD_C0/LD_C1/LD_C2/LD_SUM; each accepted word advances LD_C0->LD_C1->LD_C2->WRITE.
REQ-024 Payload SHALL be the low bus_Cx bits of each word; any nonzero bit above bus_Cx SHALL set err (load continues).
REQ-025 WRITE SHALL last one cycle with wr_en=1, wr_fn/wr_addr/wr_C* stable; next state LD_C0 with wr_addr+1, or after entry num_entries-1 -> LD_SUM (if enabled) else FIN.
REQ-026 wr_en SHALL never assert outside WRITE; wr_addr SHALL never wrap (last address 2^add_bits-1).
REQ-027 FIN SHALL last one cycle, done=1, then IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 abort in any non-IDLE state SHALL take priority: next state IDLE, no wr_en for the partial entry, no done, err=1; abort in IDLE ignored.
REQ-030 err SHALL be sticky until the next accepted start, which clears it.
REQ-031 Stream stalls (s_valid=0) SHALL hold state indefinitely with no timeout.

Reset
REQ-032 rst_n low SHALL immediately force IDLE and s_ready, wr_en, wr_fn, wr_addr, wr_C0, wr_C1, wr_C2, busy, done, err to 0.
REQ-033 Reset mid-load SHALL discard partial entry; previously written entries are not rolled back.

Configuration
REQ-034 Macro COEF_LOADER_CHECKSUM_EN defined: 32-bit XOR of all raw accepted payload words accumulated; after last WRITE, LD_SUM accepts one word; mismatch sets err; then FIN.
REQ-035 Macro undefined: no accumulator, no LD_SUM; last WRITE goes directly to FIN.

Verification
REQ-036 fn_sel=7, num_entries=2, words 0x1000_0000,0x0008_0000,0x0000_2000,1,2,3 -> two wr_en pulses, addr 0 then 1, second write C0=1,C1=2,C2=3; done one cycle; err=0.
REQ-037 fn_sel=10, num_entries=4, start -> FIN next cycle, done=1, err=1, no wr_en, s_ready never 1.
REQ-038 num_entries=128, continuous s_valid -> 128 writes, final wr_addr=127, no wrap, done once.
REQ-039 abort asserted after C1 word of entry 3 -> IDLE next cycle, entries 0-2 written only, no done, err=1; next start clears err.
REQ-040 C2 word 0x0000_4000 (bit 14 set, default widths) -> write proceeds with wr_C2=0, err=1 at done.
REQ-041 With COEF_LOADER_CHECKSUM_EN, one entry 1,2,4 then sum word 0x7 -> err=0; sum 0x6 -> err=1; without macro, a fourth word is not accepted.

Source files
------------

// File: rtl/coef_table_loader_if.sv
// Stream-in / table-write bus for coef_table_loader.
// The slave modport is the loader's side: it consumes the coefficient stream
// and drives the table write port. The master modport is the opposite side.
interface coef_table_loader_if #(
    parameter int bus_C0   = 29,
    parameter int bus_C1   = 20,
    parameter int bus_C2   = 14,
    parameter int fn_bits  = 4,
    parameter int add_bits = 7
);
    logic                s_valid;
    logic [31:0]         s_data;
    logic                s_ready;
    logic                wr_en;
    logic [fn_bits-1:0]  wr_fn;
    logic [add_bits-1:0] wr_addr;
    logic [bus_C0-1:0]   wr_C0;
    logic [bus_C1-1:0]   wr_C1;
    logic [bus_C2-1:0]   wr_C2;

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_fn, wr_addr, wr_C0, wr_C1, wr_C2
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_fn, wr_addr, wr_C0, wr_C1, wr_C2
    );
endinterface

// File: rtl/coef_table_loader.sv
// coef_table_loader: streams three coefficient words per entry (C0, C1, C2)
// into a selected function table, one table write per entry.
// Optional feature: define COEF_LOADER_CHECKSUM_EN to accumulate a 32-bit XOR
// of every accepted payload word and compare it against one trailing sum word.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; abort ignored
// LD_C0  | accepting C0 word of current entry
// LD_C1  | accepting C1 word of current entry
// LD_C2  | accepting C2 word of current entry
// WRITE  | one-cycle table write strobe for current entry
// LD_SUM | accepting checksum word (COEF_LOADER_CHECKSUM_EN only)
// FIN    | one-cycle done pulse, back to IDLE
module coef_table_loader #(
    parameter int bus_C0   = 29,
    parameter int bus_C1   = 20,
    parameter int bus_C2   = 14,
    parameter int fn_bits  = 4,
    parameter int add_bits = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [fn_bits-1:0]  fn_sel,
    input  logic [add_bits:0]   num_entries,
    input  logic                abort,
    coef_table_loader_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        LD_C0,
        LD_C1,
        LD_C2,
        WRITE,
`ifdef COEF_LOADER_CHECKSUM_EN
        LD_SUM,
`endif
        FIN
    } state_t;

    localparam logic [add_bits:0] MAX_ENT = {1'b1, {add_bits{1'b0}}};
    localparam logic [31:0] MASK_C0 = 32'((64'd1 << bus_C0) - 64'd1);
    localparam logic [31:0] MASK_C1 = 32'((64'd1 << bus_C1) - 64'd1);
    localparam logic [31:0] MASK_C2 = 32'((64'd1 << bus_C2) - 64'd1);

    state_t              state_q, state_d;
    logic                err_q, err_d;
    logic [fn_bits-1:0]  fn_q, fn_d;
    logic [add_bits:0]   num_q, num_d;
    logic [add_bits-1:0] addr_q, addr_d;
    logic [bus_C0-1:0]   c0_q, c0_d;
    logic [bus_C1-1:0]   c1_q, c1_d;
    logic [bus_C2-1:0]   c2_q, c2_d;
    logic                s_ready_q, wr_en_q, busy_q, done_q;
`ifdef COEF_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    logic accept;
    logic last_entry;

    assign accept     = bus.s_valid && s_ready_q;
    assign last_entry = ({1'b0, addr_q} == (num_q - (add_bits+1)'(1)));

    // Next-state and datapath update; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fn_d    = fn_q;
        num_d   = num_q;
        addr_d  = addr_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
`ifdef COEF_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    fn_d   = fn_sel;
                    num_d  = num_entries;
                    addr_d = '0;
`ifdef COEF_LOADER_CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if ((32'(fn_sel) > 32'd9) || (num_entries > MAX_ENT)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else if (num_entries == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = LD_C0;
                    end
                end
            end
            LD_C0: begin
                if (accept) begin
                    c0_d = bus.s_data[bus_C0-1:0];
                    if ((bus.s_data & ~MASK_C0) != '0) err_d = 1'b1;
`ifdef COEF_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ bus.s_data;
`endif
                    state_d = LD_C1;
                end
            end
            LD_C1: begin
                if (accept) begin
                    c1_d = bus.s_data[bus_C1-1:0];
                    if ((bus.s_data & ~MASK_C1) != '0) err_d = 1'b1;
`ifdef COEF_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ bus.s_data;
`endif
                    state_d = LD_C2;
                end
            end
            LD_C2: begin
                if (accept) begin
                    c2_d = bus.s_data[bus_C2-1:0];
                    if ((bus.s_data & ~MASK_C2) != '0) err_d = 1'b1;
`ifdef COEF_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ bus.s_data;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Address stops at the last entry so it never wraps.
                if (last_entry) begin
`ifdef COEF_LOADER_CHECKSUM_EN
                    state_d = LD_SUM;
`else
                    state_d = FIN;
`endif
                end else begin
                    addr_d  = addr_q + add_bits'(1);
                    state_d = LD_C0;
                end
            end
`ifdef COEF_LOADER_CHECKSUM_EN
            LD_SUM: begin
                if (accept) begin
                    if (bus.s_data != sum_q) err_d = 1'b1;
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // State, datapath and outputs registered; outputs decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            fn_q      <= '0;
            num_q     <= '0;
            addr_q    <= '0;
            c0_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef COEF_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            fn_q      <= fn_d;
            num_q     <= num_d;
            addr_q    <= addr_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
`ifdef COEF_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            s_ready_q <= (state_d == LD_C0) || (state_d == LD_C1) ||
                         (state_d == LD_C2) || (state_d == LD_SUM);
`else
            s_ready_q <= (state_d == LD_C0) || (state_d == LD_C1) ||
                         (state_d == LD_C2);
`endif
            wr_en_q   <= (state_d == WRITE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == FIN);
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_fn   = fn_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_C0   = c0_q;
    assign bus.wr_C1   = c1_q;
    assign bus.wr_C2   = c2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_coef_table_loader.sv
// Directed bench for coef_table_loader (default widths).
module tb_coef_table_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] fn_sel;
    logic [7:0] num_entries;
    logic       abort;
    logic       busy, done, err;

    coef_table_loader_if #(.bus_C0(29), .bus_C1(20), .bus_C2(14), .fn_bits(4), .add_bits(7)) bus ();

    coef_table_loader #(.bus_C0(29), .bus_C1(20), .bus_C2(14), .fn_bits(4), .add_bits(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fn_sel      (fn_sel),
        .num_entries (num_entries),
        .abort       (abort),
        .bus         (bus.slave),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [3:0]  fn;
        logic [6:0]  addr;
        logic [28:0] c0;
        logic [19:0] c1;
        logic [13:0] c2;
    } wr_rec_t;

    wr_rec_t wr_log[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      done_cnt = 0;
    int      acc_cnt = 0;
    bit      rdy_seen = 0;
    int      dbase, abase, bad_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe table writes, done pulses and stream handshakes mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                wr_log.push_back('{bus.wr_fn, bus.wr_addr, bus.wr_C0, bus.wr_C1, bus.wr_C2});
            end
            if (done) done_cnt++;
            if (bus.s_ready) rdy_seen = 1;
            if (bus.s_valid && bus.s_ready) acc_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [3:0] f, input logic [7:0] n);
        start       = 1'b1;
        fn_sel      = f;
        num_entries = n;
        sync();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        @(negedge clk);
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 32'(bus.s_ready), 32'd1);
        sync();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int t = 0;
        @(negedge clk);
        while (!done && t < bound) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; fn_sel = '0; num_entries = '0; abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_ready", 32'(bus.s_ready), 0);
        check("rst_wren",  32'(bus.wr_en), 0);
        check("rst_addr",  32'(bus.wr_addr), 0);
        sync();
        rst_n = 1'b1;
        sync();

        // Two entries, with a start pulse mid-load that must be ignored.
        wr_log.delete(); dbase = done_cnt;
        start_load(4'd7, 8'd2);
        @(negedge clk);
        check("t1_busy", 32'(busy), 1);
        sync();
        send_word(32'h1000_0000); send_word(32'h0008_0000); send_word(32'h0000_2000);
        start_load(4'd3, 8'd5);
        send_word(32'd1); send_word(32'd2); send_word(32'd3);
`ifdef COEF_LOADER_CHECKSUM_EN
        send_word(32'h1008_2000);
`endif
        wait_done("t1_done", 50);
        check("t1_err", 32'(err), 0);
        sync();
        @(negedge clk);
        check("t1_done_once", 32'(done_cnt - dbase), 1);
        check("t1_idle", 32'(busy), 0);
        check("t1_nwr", 32'(wr_log.size()), 2);
        if (wr_log.size() == 2) begin
            check("t1_a0",  32'(wr_log[0].addr), 0);
            check("t1_fn0", 32'(wr_log[0].fn), 7);
            check("t1_c00", 32'(wr_log[0].c0), 32'h1000_0000);
            check("t1_c10", 32'(wr_log[0].c1), 32'h0008_0000);
            check("t1_c20", 32'(wr_log[0].c2), 32'h0000_2000);
            check("t1_a1",  32'(wr_log[1].addr), 1);
            check("t1_fn1", 32'(wr_log[1].fn), 7);
            check("t1_c01", 32'(wr_log[1].c0), 1);
            check("t1_c11", 32'(wr_log[1].c1), 2);
            check("t1_c21", 32'(wr_log[1].c2), 3);
        end
        sync();

        // Illegal function select: straight to FIN with err.
        wr_log.delete(); rdy_seen = 0;
        start_load(4'd10, 8'd4);
        @(negedge clk);
        check("t2_done", 32'(done), 1);
        check("t2_err",  32'(err), 1);
        sync();
        @(negedge clk);
        check("t2_done_low",  32'(done), 0);
        check("t2_idle",      32'(busy), 0);
        check("t2_err_stick", 32'(err), 1);
        check("t2_nwr",       32'(wr_log.size()), 0);
        check("t2_rdy",       32'(rdy_seen), 0);
        sync();

        // Zero entries clears the sticky err and finishes cleanly.
        start_load(4'd2, 8'd0);
        @(negedge clk);
        check("t2z_done", 32'(done), 1);
        check("t2z_err",  32'(err), 0);
        sync();

        // Entry count just above table size.
        start_load(4'd0, 8'd129);
        @(negedge clk);
        check("t2o_err", 32'(err), 1);
        check("t2o_nwr", 32'(wr_log.size()), 0);
        sync();
        sync();

        // Full table with continuous valid.
        wr_log.delete(); dbase = done_cnt;
        start_load(4'd4, 8'd128);
        bus.s_valid = 1'b1; bus.s_data = '0;
        wait_done("t3_done", 700);
        sync();
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("t3_nwr", 32'(wr_log.size()), 128);
        bad_addr = 0;
        foreach (wr_log[i]) if (32'(wr_log[i].addr) != i) bad_addr++;
        check("t3_addr_seq", 32'(bad_addr), 0);
        check("t3_final_addr", 32'(bus.wr_addr), 127);
        check("t3_done_once", 32'(done_cnt - dbase), 1);
        check("t3_err", 32'(err), 0);
        sync();

        // Abort after the C1 word of entry 3.
        wr_log.delete(); dbase = done_cnt;
        start_load(4'd2, 8'd5);
        for (int e = 0; e < 3; e++) begin
            send_word(32'(e * 3 + 1)); send_word(32'(e * 3 + 2)); send_word(32'(e * 3 + 3));
        end
        send_word(32'd10); send_word(32'd11);
        abort = 1'b1;
        sync();
        abort = 1'b0;
        @(negedge clk);
        check("t4_idle",  32'(busy), 0);
        check("t4_err",   32'(err), 1);
        check("t4_ready", 32'(bus.s_ready), 0);
        check("t4_nwr",   32'(wr_log.size()), 3);
        check("t4_nodone", 32'(done_cnt - dbase), 0);
        sync();
        start_load(4'd2, 8'd0);
        @(negedge clk);
        check("t4_err_clr", 32'(err), 0);
        sync();
        sync();
        abort = 1'b1;
        sync();
        abort = 1'b0;
        @(negedge clk);
        check("t4_idle_abort_err",  32'(err), 0);
        check("t4_idle_abort_busy", 32'(busy), 0);
        sync();

        // C2 word with a bit above the field width.
        wr_log.delete();
        start_load(4'd9, 8'd1);
        send_word(32'd5); send_word(32'd6); send_word(32'h0000_4000);
`ifdef COEF_LOADER_CHECKSUM_EN
        send_word(32'h0000_4003);
`endif
        wait_done("t5_done", 20);
        check("t5_err", 32'(err), 1);
        sync();
        check("t5_nwr", 32'(wr_log.size()), 1);
        if (wr_log.size() == 1) begin
            check("t5_fn", 32'(wr_log[0].fn), 9);
            check("t5_c0", 32'(wr_log[0].c0), 5);
            check("t5_c1", 32'(wr_log[0].c1), 6);
            check("t5_c2", 32'(wr_log[0].c2), 0);
        end

`ifdef COEF_LOADER_CHECKSUM_EN
        // Checksum word correct, then wrong.
        start_load(4'd1, 8'd1);
        send_word(32'd1); send_word(32'd2); send_word(32'd4); send_word(32'd7);
        wait_done("t6_done_ok", 20);
        check("t6_sum_ok", 32'(err), 0);
        sync();
        start_load(4'd1, 8'd1);
        send_word(32'd1); send_word(32'd2); send_word(32'd4); send_word(32'd6);
        wait_done("t6_done_bad", 20);
        check("t6_sum_bad", 32'(err), 1);
        sync();
`else
        // No trailing word is taken without the checksum feature.
        abase = acc_cnt; dbase = done_cnt;
        start_load(4'd1, 8'd1);
        send_word(32'd1); send_word(32'd2); send_word(32'd4);
        bus.s_valid = 1'b1; bus.s_data = 32'd7;
        repeat (6) sync();
        bus.s_valid = 1'b0;
        check("t6_accepts", 32'(acc_cnt - abase), 3);
        check("t6_done",    32'(done_cnt - dbase), 1);
        check("t6_err",     32'(err), 0);
        check("t6_ready",   32'(bus.s_ready), 0);
        sync();
`endif

        // Asynchronous reset mid-load.
        wr_log.delete();
        start_load(4'd5, 8'd3);
        send_word(32'd1); send_word(32'd2); send_word(32'd3); send_word(32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_busy",  32'(busy), 0);
        check("t7_ready", 32'(bus.s_ready), 0);
        check("t7_addr",  32'(bus.wr_addr), 0);
        check("t7_fn",    32'(bus.wr_fn), 0);
        check("t7_c0",    32'(bus.wr_C0), 0);
        check("t7_done",  32'(done), 0);
        check("t7_nwr",   32'(wr_log.size()), 1);
        sync();
        rst_n = 1'b1;
        sync();
        @(negedge clk);
        check("t7_post_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
